// File: rtl/ysyx_22050710_sram_arbiter_if.sv
// SRAM-like request/response bundle shared by the masters and the memory port.
// The master modport drives the request fields; the slave modport answers with addr_ok/data_ok/rdata.
interface ysyx_22050710_sram_arbiter_if #(
  parameter int ADDR_WD  = 32,
  parameter int DATA_WD  = 64,
  parameter int WMASK_WD = 8
);
  logic                req;
  logic                op;
  logic [1:0]          size;
  logic [ADDR_WD-1:0]  addr;
  logic [WMASK_WD-1:0] wstrb;
  logic [DATA_WD-1:0]  wdata;
  logic                addr_ok;
  logic                data_ok;
  logic [DATA_WD-1:0]  rdata;

  modport master (
    output req, op, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, op, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/ysyx_22050710_sram_arbiter.sv
// Two-master SRAM port arbiter: grant locked until addr_ok, in-order owner FIFO routes data_ok back.
// Define ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed M1 (data master) priority.
module ysyx_22050710_sram_arbiter #(
  parameter int SRAM_ADDR_WD    = 32,
  parameter int SRAM_DATA_WD    = 64,
  parameter int SRAM_WMASK_WD   = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                         i_clk,
  input logic                         i_rst_n,
  ysyx_22050710_sram_arbiter_if.slave m0,
  ysyx_22050710_sram_arbiter_if.slave m1,
  ysyx_22050710_sram_arbiter_if.master s
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic             id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             lock;
  logic             lock_owner;
`ifdef ARB_ROUND_ROBIN_EN
  logic             rr_last;
`endif

  logic                     full;
  logic                     grant;
  logic                     s_req;
  logic                     fire;
  logic                     pop;
  logic                     head;
  logic                     sel_op;
  logic [1:0]               sel_size;
  logic [SRAM_ADDR_WD-1:0]  sel_addr;
  logic [SRAM_WMASK_WD-1:0] sel_wstrb;
  logic [SRAM_DATA_WD-1:0]  sel_wdata;

  assign full = (count == CNT_W'(MAX_OUTSTANDING));

  // A locked owner always wins so a presented request never changes under the memory.
  always_comb begin
    grant = m1.req;
`ifdef ARB_ROUND_ROBIN_EN
    if (m0.req && m1.req) grant = ~rr_last;
`endif
    if (lock) grant = lock_owner;
  end

  // Reset gates the request so the memory port goes quiet immediately, not at the next edge.
  assign s_req = i_rst_n & (m0.req | m1.req) & ~full;
  assign fire  = s_req & s.addr_ok;
  assign head  = id_fifo[rd_ptr];
  assign pop   = s.data_ok & (count != '0);

  always_comb begin
    sel_op    = 1'b0;
    sel_size  = 2'b00;
    sel_addr  = '0;
    sel_wstrb = '0;
    sel_wdata = '0;
    if (s_req) begin
      if (grant) begin
        sel_op    = m1.op;
        sel_size  = m1.size;
        sel_addr  = m1.addr;
        sel_wstrb = m1.wstrb;
        sel_wdata = m1.wdata;
      end else begin
        sel_op    = m0.op;
        sel_size  = m0.size;
        sel_addr  = m0.addr;
        sel_wstrb = m0.wstrb;
        sel_wdata = m0.wdata;
      end
    end
  end

  assign s.req   = s_req;
  assign s.op    = sel_op;
  assign s.size  = sel_size;
  assign s.addr  = sel_addr;
  assign s.wstrb = sel_wstrb;
  assign s.wdata = sel_wdata;

  assign m0.addr_ok = fire & ~grant;
  assign m1.addr_ok = fire & grant;
  assign m0.data_ok = pop & ~head;
  assign m1.data_ok = pop & head;
  assign m0.rdata   = s.rdata;
  assign m1.rdata   = s.rdata;

  // Owner IDs are payload; only the pointers and count need reset.
  always_ff @(posedge i_clk) begin
    if (fire) id_fifo[wr_ptr] <= grant;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      lock       <= 1'b0;
      lock_owner <= 1'b0;
    end else begin
      if (fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fire, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (fire) begin
        lock <= 1'b0;
      end else if (s_req) begin
        lock       <= 1'b1;
        lock_owner <= grant;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_last <= 1'b0;
    else if (fire) rr_last <= grant;
  end
`endif

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Randomized bench for the SRAM arbiter, checked against a queue-based reference of the arbitration rules.
module tb_ysyx_22050710_sram_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int MW   = 8;
  localparam int MAXO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050710_sram_arbiter_if #(.ADDR_WD(AW), .DATA_WD(DW), .WMASK_WD(MW)) m0_if ();
  ysyx_22050710_sram_arbiter_if #(.ADDR_WD(AW), .DATA_WD(DW), .WMASK_WD(MW)) m1_if ();
  ysyx_22050710_sram_arbiter_if #(.ADDR_WD(AW), .DATA_WD(DW), .WMASK_WD(MW)) s_if ();

  ysyx_22050710_sram_arbiter #(
    .SRAM_ADDR_WD(AW), .SRAM_DATA_WD(DW), .SRAM_WMASK_WD(MW), .MAX_OUTSTANDING(MAXO)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  int n_vec = 0;
  int n_err = 0;

  // Master-side pending requests and the reference model state
  bit          mreq  [2];
  bit          mop   [2];
  logic [1:0]  msize [2];
  logic [31:0] maddr [2];
  logic [7:0]  mstrb [2];
  logic [63:0] mwdata[2];
  bit          owner_q[$];
  bit          lock_v, lock_o, rr_last;
  logic        s_aok, s_dok;
  logic [63:0] s_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    m0_if.req = mreq[0]; m0_if.op = mop[0]; m0_if.size = msize[0];
    m0_if.addr = maddr[0]; m0_if.wstrb = mstrb[0]; m0_if.wdata = mwdata[0];
    m1_if.req = mreq[1]; m1_if.op = mop[1]; m1_if.size = msize[1];
    m1_if.addr = maddr[1]; m1_if.wstrb = mstrb[1]; m1_if.wdata = mwdata[1];
    s_if.addr_ok = s_aok; s_if.data_ok = s_dok; s_if.rdata = s_rd;
  endtask

  task automatic new_inputs(input int dok_pct, input bit stray);
    for (int i = 0; i < 2; i++) begin
      if (!mreq[i] && $urandom_range(0, 99) < 50) begin
        mreq[i]   = 1'b1;
        mop[i]    = 1'($urandom_range(0, 1));
        msize[i]  = 2'($urandom_range(0, 3));
        maddr[i]  = $urandom;
        mstrb[i]  = 8'($urandom);
        mwdata[i] = {$urandom, $urandom};
      end
    end
    s_aok = ($urandom_range(0, 99) < 65);
    s_dok = stray ? 1'b1 : ($urandom_range(0, 99) < dok_pct);
    s_rd  = ($urandom_range(0, 7) == 0) ? 64'hDEAD_BEEF_0000_0001 : {$urandom, $urandom};
    drive();
  endtask

  task automatic check_and_model();
    bit exp_req, gnt, fire, pop, owner;
    exp_req = (mreq[0] || mreq[1]) && (owner_q.size() < MAXO);
    gnt = mreq[1];
`ifdef ARB_ROUND_ROBIN_EN
    if (mreq[0] && mreq[1]) gnt = !rr_last;
`endif
    if (lock_v) gnt = lock_o;
    chk("s_req", 64'(s_if.req), 64'(exp_req));
    if (exp_req) begin
      chk("s_addr", 64'(s_if.addr), 64'(maddr[gnt]));
      chk("s_wdata", s_if.wdata, mwdata[gnt]);
      chk("s_ctl", 64'({s_if.op, s_if.size, s_if.wstrb}), 64'({mop[gnt], msize[gnt], mstrb[gnt]}));
    end else begin
      chk("s_idle", 64'({s_if.op, s_if.size, s_if.wstrb, s_if.addr}), 64'd0);
      chk("s_idle_wdata", s_if.wdata, 64'd0);
    end
    fire = exp_req && s_aok;
    chk("m0_addr_ok", 64'(m0_if.addr_ok), 64'(fire && !gnt));
    chk("m1_addr_ok", 64'(m1_if.addr_ok), 64'(fire && gnt));
    pop   = s_dok && (owner_q.size() > 0);
    owner = pop ? owner_q[0] : 1'b0;
    chk("m0_data_ok", 64'(m0_if.data_ok), 64'(pop && !owner));
    chk("m1_data_ok", 64'(m1_if.data_ok), 64'(pop && owner));
    if (pop) begin
      if (owner) chk("m1_rdata", m1_if.rdata, s_rd);
      else       chk("m0_rdata", m0_if.rdata, s_rd);
      void'(owner_q.pop_front());
    end
    if (fire) begin
      owner_q.push_back(gnt);
      mreq[gnt] = 1'b0;
      lock_v    = 1'b0;
      rr_last   = gnt;
    end else if (exp_req) begin
      lock_v = 1'b1;
      lock_o = gnt;
    end
  endtask

  task automatic step(input int dok_pct, input bit stray);
    new_inputs(dok_pct, stray);
    @(negedge clk);
    check_and_model();
  endtask

  task automatic run_phase(input int cycles, input int dok_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      step(dok_pct, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_req"}, 64'(s_if.req), 64'd0);
    chk({tag, "_s_addr"}, 64'(s_if.addr), 64'd0);
    chk({tag, "_m0_aok"}, 64'(m0_if.addr_ok), 64'd0);
    chk({tag, "_m1_aok"}, 64'(m1_if.addr_ok), 64'd0);
    chk({tag, "_m0_dok"}, 64'(m0_if.data_ok), 64'd0);
    chk({tag, "_m1_dok"}, 64'(m1_if.data_ok), 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // first cycle out of reset carries a stray data_ok into an empty FIFO
    step(0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mreq[i] = 1'b0; mop[i] = 1'b0; msize[i] = 2'b00;
      maddr[i] = '0; mstrb[i] = '0; mwdata[i] = '0;
    end
    lock_v = 1'b0; lock_o = 1'b0; rr_last = 1'b0;
    s_aok = 1'b1; s_dok = 1'b1; s_rd = 64'hDEAD_BEEF_0000_0001;
    mreq[0] = 1'b1; mreq[1] = 1'b1;
    drive();
    #2;
    check_reset_outputs("rst0");
    mreq[0] = 1'b0; mreq[1] = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    release_reset();

    run_phase(300, 50);
    run_phase(200, 5);

    // asynchronous reset in the middle of traffic
    s_dok = 1'b1;
    drive();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    owner_q.delete();
    lock_v = 1'b0; rr_last = 1'b0;
    release_reset();

    run_phase(300, 40);
    run_phase(200, 90);
    run_phase(200, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
